vga_fb_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/fb_clear_engine.sv | 65 ++++++
 rtl/vga_fb_arbiter.sv | 145 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter.
package vga_pkg;

    // 640x480 @ 60 Hz horizontal timing, in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Framebuffer geometry: each cell covers 8x8 screen pixels
    localparam int SCALE_LOG2 = 3;
    localparam int FB_W       = 80;
    localparam int FB_H       = 60;
    localparam int FB_CELLS   = FB_W * FB_H;
    localparam int ADDR_W     = 13;
    localparam int PIX_W      = 9;

    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_BUSY = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Clear-screen engine: walks every framebuffer cell once, writing a latched
// colour on each cycle the arbiter grants it the RAM.
//
//   state    | meaning
//   CLR_IDLE | waiting for a start pulse, no RAM writes
//   CLR_BUSY | filling cells 0..4799 on granted cycles
module fb_clear_engine
    import vga_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic [PIX_W-1:0]  i_Color,
    input  logic              i_Grant,
    output logic              o_We,
    output logic [ADDR_W-1:0] o_Addr,
    output logic [PIX_W-1:0]  o_Data,
    output logic              o_Busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_CELLS - 1);

    clr_state_t        r_State;
    logic [ADDR_W-1:0] r_Count;
    logic [PIX_W-1:0]  r_Color;
    logic              w_Write;

    assign w_Write = (r_State == CLR_BUSY) && i_Grant;

    // State, address counter and latched fill colour
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= CLR_IDLE;
            r_Count <= '0;
            r_Color <= '0;
        end else begin
            case (r_State)
                CLR_IDLE: begin
                    if (i_Start) begin
                        r_State <= CLR_BUSY;
                        r_Count <= '0;
                        r_Color <= i_Color;
                    end
                end
                CLR_BUSY: begin
                    if (w_Write) begin
                        if (r_Count == LAST_ADDR) begin
                            r_State <= CLR_IDLE;
                            r_Count <= '0;
                        end else begin
                            r_Count <= r_Count + 1'b1;
                        end
                    end
                end
                default: r_State <= CLR_IDLE;
            endcase
        end
    end

    assign o_We   = w_Write;
    assign o_Addr = r_Count;
    assign o_Data = r_Color;
    assign o_Busy = (r_State == CLR_BUSY);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: scan-out owns every 8th active cycle, the clear engine
// or the host owns the rest. Video outputs lag the timing inputs by 2 cycles.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [9:0]        i_Column,
    input  logic [9:0]        i_Row,
    input  logic              i_HSync,
    input  logic              i_VSync,
    input  logic              i_Wr_Valid,
    output logic              o_Wr_Ready,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [PIX_W-1:0]  i_Wr_Data,
    input  logic              i_Clear_Start,
    input  logic [PIX_W-1:0]  i_Clear_Color,
    output logic              o_Busy,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_We,
    output logic [PIX_W-1:0]  o_Mem_WData,
    input  logic [PIX_W-1:0]  i_Mem_RData,
    output logic              o_HSync,
    output logic              o_VSync,
    output logic [2:0]        o_Red,
    output logic [2:0]        o_Grn,
    output logic [2:0]        o_Blu,
    output logic              o_Frame_Start
);

    logic                  w_Active;
    logic                  w_Slot;
    logic [9-SCALE_LOG2:0] w_Cell_Row;
    logic [9-SCALE_LOG2:0] w_Cell_Col;
    logic [ADDR_W-1:0]     w_Scan_Addr;
    logic                  w_Host_Fire;
    logic                  w_Host_In_Range;
    logic                  w_Clr_We;
    logic [ADDR_W-1:0]     w_Clr_Addr;
    logic [PIX_W-1:0]      w_Clr_Data;
    logic                  w_Clr_Busy;
    logic [PIX_W-1:0]      w_Pixel_Out;

    logic                  r_Slot_D1;
    logic [PIX_W-1:0]      r_Pixel;
    logic                  r_Active_D1, r_Active_D2;
    logic                  r_HSync_D1, r_HSync_D2;
    logic                  r_VSync_D1, r_VSync_D2;
    logic                  r_Frame_Start;

    assign w_Active   = (i_Column < 10'(H_ACTIVE)) && (i_Row < 10'(V_ACTIVE));
    assign w_Slot     = w_Active && (i_Column[SCALE_LOG2-1:0] == '0);
    assign w_Cell_Row = i_Row[9:SCALE_LOG2];
    assign w_Cell_Col = i_Column[9:SCALE_LOG2];

    // row*80 as row*64 + row*16 keeps a multiplier out of the address path
    assign w_Scan_Addr = (ADDR_W'(w_Cell_Row) << 6) + (ADDR_W'(w_Cell_Row) << 4)
                       + ADDR_W'(w_Cell_Col);

    assign o_Wr_Ready      = !i_Reset && !w_Slot && !w_Clr_Busy;
    assign w_Host_Fire     = i_Wr_Valid && o_Wr_Ready;
    assign w_Host_In_Range = (i_Wr_Addr < ADDR_W'(FB_CELLS));

    fb_clear_engine u_clear (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Start (i_Clear_Start),
        .i_Color (i_Clear_Color),
        .i_Grant (!w_Slot),
        .o_We    (w_Clr_We),
        .o_Addr  (w_Clr_Addr),
        .o_Data  (w_Clr_Data),
        .o_Busy  (w_Clr_Busy)
    );

    assign o_Busy = w_Clr_Busy;

    // RAM port mux: scan slot first, then clear engine, then host
    always_comb begin
        o_Mem_Addr  = w_Scan_Addr;
        o_Mem_We    = 1'b0;
        o_Mem_WData = '0;
        if (!w_Slot) begin
            if (w_Clr_Busy) begin
                o_Mem_Addr  = w_Clr_Addr;
                o_Mem_We    = w_Clr_We && !i_Reset;
                o_Mem_WData = w_Clr_Data;
            end else begin
                o_Mem_Addr  = i_Wr_Addr;
                o_Mem_We    = w_Host_Fire && w_Host_In_Range;
                o_Mem_WData = i_Wr_Data;
            end
        end
    end

    // Pixel register captures read data the cycle after each scan slot
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Slot_D1 <= 1'b0;
            r_Pixel   <= '0;
        end else begin
            r_Slot_D1 <= w_Slot;
            if (r_Slot_D1) begin
                r_Pixel <= i_Mem_RData;
            end
        end
    end

    // Two-stage delay of active flag and syncs to line up with the pixel register
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Active_D1 <= 1'b0;
            r_Active_D2 <= 1'b0;
            r_HSync_D1  <= 1'b1;
            r_HSync_D2  <= 1'b1;
            r_VSync_D1  <= 1'b1;
            r_VSync_D2  <= 1'b1;
        end else begin
            r_Active_D1 <= w_Active;
            r_Active_D2 <= r_Active_D1;
            r_HSync_D1  <= i_HSync;
            r_HSync_D2  <= r_HSync_D1;
            r_VSync_D1  <= i_VSync;
            r_VSync_D2  <= r_VSync_D1;
        end
    end

    // Frame start pulse one cycle after the timing generator reaches (0,0)
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Frame_Start <= 1'b0;
        end else begin
            r_Frame_Start <= (i_Column == '0) && (i_Row == '0);
        end
    end

    assign w_Pixel_Out   = r_Active_D2 ? r_Pixel : '0;
    assign o_Red         = w_Pixel_Out[8:6];
    assign o_Grn         = w_Pixel_Out[5:3];
    assign o_Blu         = w_Pixel_Out[2:0];
    assign o_HSync       = r_HSync_D2;
    assign o_VSync       = r_VSync_D2;
    assign o_Frame_Start = r_Frame_Start;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic              i_Clk = 1'b0;
    logic              i_Reset;
    logic [9:0]        i_Column, i_Row;
    logic              i_HSync, i_VSync;
    logic              i_Wr_Valid, o_Wr_Ready;
    logic [ADDR_W-1:0] i_Wr_Addr;
    logic [PIX_W-1:0]  i_Wr_Data;
    logic              i_Clear_Start;
    logic [PIX_W-1:0]  i_Clear_Color;
    logic              o_Busy;
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic              o_Mem_We;
    logic [PIX_W-1:0]  o_Mem_WData;
    logic [PIX_W-1:0]  i_Mem_RData;
    logic              o_HSync, o_VSync;
    logic [2:0]        o_Red, o_Grn, o_Blu;
    logic              o_Frame_Start;
    logic [8:0]        rgb;

    int n_cmp = 0;
    int n_err = 0;
    int cur_col, cur_row, h1_col, h1_row, h2_col, h2_row;
    logic [8:0] exp_fb [0:4799];
    logic [8:0] ram [0:8191];

    always #5 i_Clk = ~i_Clk;
    assign rgb = {o_Red, o_Grn, o_Blu};

    vga_fb_arbiter dut (
        .i_Clk         (i_Clk),
        .i_Reset       (i_Reset),
        .i_Column      (i_Column),
        .i_Row         (i_Row),
        .i_HSync       (i_HSync),
        .i_VSync       (i_VSync),
        .i_Wr_Valid    (i_Wr_Valid),
        .o_Wr_Ready    (o_Wr_Ready),
        .i_Wr_Addr     (i_Wr_Addr),
        .i_Wr_Data     (i_Wr_Data),
        .i_Clear_Start (i_Clear_Start),
        .i_Clear_Color (i_Clear_Color),
        .o_Busy        (o_Busy),
        .o_Mem_Addr    (o_Mem_Addr),
        .o_Mem_We      (o_Mem_We),
        .o_Mem_WData   (o_Mem_WData),
        .i_Mem_RData   (i_Mem_RData),
        .o_HSync       (o_HSync),
        .o_VSync       (o_VSync),
        .o_Red         (o_Red),
        .o_Grn         (o_Grn),
        .o_Blu         (o_Blu),
        .o_Frame_Start (o_Frame_Start)
    );

    // Single-port RAM, one-cycle synchronous read
    always @(posedge i_Clk) begin
        if (o_Mem_We) ram[o_Mem_Addr] <= o_Mem_WData;
        i_Mem_RData <= ram[o_Mem_Addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (col %0d row %0d)", tag, got, exp, cur_col, cur_row);
        end
    endtask

    function automatic logic raw_hs(input int c);
        return !(c >= 656 && c < 752);
    endfunction

    function automatic logic raw_vs(input int r);
        return !(r >= 490 && r < 492);
    endfunction

    function automatic logic is_act(input int c, input int r);
        return (c < 640) && (r < 480);
    endfunction

    function automatic logic is_slot(input int c, input int r);
        return is_act(c, r) && ((c % 8) == 0);
    endfunction

    task automatic drive_pos(input int c, input int r);
        cur_col  = c;
        cur_row  = r;
        i_Column = 10'(c);
        i_Row    = 10'(r);
        i_HSync  = raw_hs(c);
        i_VSync  = raw_vs(r);
    endtask

    // One clock: shift position history, advance the timing generator
    task automatic step();
        int nc, nr;
        @(posedge i_Clk);
        #1;
        h2_col = h1_col; h2_row = h1_row;
        h1_col = cur_col; h1_row = cur_row;
        nc = cur_col + 1;
        nr = cur_row;
        if (nc == 800) begin
            nc = 0;
            nr = (nr == 524) ? 0 : nr + 1;
        end
        drive_pos(nc, nr);
        #1;
    endtask

    task automatic host_wr(input int a, input logic [8:0] d, input logic exp_we);
        logic [8:0] old;
        old = ram[a];
        i_Wr_Valid = 1'b1;
        i_Wr_Addr  = 13'(a);
        i_Wr_Data  = d;
        #1;
        for (int k = 0; k < 20 && !o_Wr_Ready; k++) step();
        check_val("host_ready", o_Wr_Ready, 1);
        check_val("host_we", o_Mem_We, exp_we);
        check_val("host_addr", o_Mem_Addr, a);
        step();
        i_Wr_Valid = 1'b0;
        #1;
        check_val("host_ram", ram[a], exp_we ? d : old);
        if (a < 4800) exp_fb[a] = d;
    endtask

    initial begin
        int wr, bad_seq, bad_rdy, bad_gap, bad_slot, bad, fs_cnt, rdy_row0, first_addr;
        logic [8:0] ex_pix;

        h1_col = 0; h1_row = 0; h2_col = 0; h2_row = 0;
        i_Reset = 1'b1;
        drive_pos(700, 490);
        i_Wr_Valid    = 1'b1;
        i_Wr_Addr     = 13'd3;
        i_Wr_Data     = 9'h1FF;
        i_Clear_Start = 1'b1;
        i_Clear_Color = 9'h0AA;

        // Reset holds syncs high even while raw syncs are low
        repeat (3) step();
        check_val("rst_ready", o_Wr_Ready, 0);
        check_val("rst_we", o_Mem_We, 0);
        check_val("rst_hsync", o_HSync, 1);
        check_val("rst_vsync", o_VSync, 1);
        check_val("rst_rgb", rgb, 0);
        check_val("rst_busy", o_Busy, 0);
        check_val("rst_fstart", o_Frame_Start, 0);
        i_Wr_Valid = 1'b0;
        i_Clear_Start = 1'b0;
        i_Reset = 1'b0;
        step();
        step();
        check_val("rst_no_clear", o_Busy, 0);
        check_val("hsync_pipe", o_HSync, 0);
        check_val("vsync_pipe", o_VSync, 0);

        // Clear with 0x007 during vertical blanking: one write every cycle
        drive_pos(0, 481);
        step();
        i_Clear_Start = 1'b1;
        i_Clear_Color = 9'h007;
        #1;
        check_val("blank_ready", o_Wr_Ready, 1);
        check_val("clr_pre_busy", o_Busy, 0);
        step();
        i_Clear_Start = 1'b0;
        i_Clear_Color = 9'h155;
        #1;
        check_val("clr_busy_rise", o_Busy, 1);
        wr = 0; bad_seq = 0; bad_rdy = 0; bad_gap = 0;
        for (int cyc = 0; cyc < 6000 && o_Busy; cyc++) begin
            if (o_Wr_Ready) bad_rdy++;
            if (o_Mem_We) begin
                if (o_Mem_Addr != 13'(wr) || o_Mem_WData != 9'h007) bad_seq++;
                wr++;
            end else begin
                bad_gap++;
            end
            step();
        end
        check_val("clr_done", o_Busy, 0);
        check_val("clr_writes", wr, 4800);
        check_val("clr_seq", bad_seq, 0);
        check_val("clr_ready", bad_rdy, 0);
        check_val("clr_blank_gap", bad_gap, 0);
        bad = 0;
        for (int i = 0; i < 4800; i++) begin
            if (ram[i] != 9'h007) bad++;
            exp_fb[i] = 9'h007;
        end
        check_val("clr_ram", bad, 0);

        // Host writes in blanking, including an out-of-range drop
        host_wr(81, 9'h1C0, 1'b1);
        host_wr(0, 9'h155, 1'b1);
        host_wr(82, 9'h038, 1'b1);
        host_wr(163, 9'h1FF, 1'b1);
        host_wr(4799, 9'h0AA, 1'b1);
        host_wr(4800, 9'h1FF, 1'b0);

        // Scan rows 0..16 with a dropped host write held pending through row 0
        drive_pos(790, 524);
        i_Wr_Valid = 1'b1;
        i_Wr_Addr  = 13'd4800;
        i_Wr_Data  = 9'h1FF;
        #1;
        step();
        step();
        fs_cnt = 0; rdy_row0 = 0;
        for (int cyc = 0; cyc < 20000 && cur_row != 17; cyc++) begin
            ex_pix = 9'h000;
            if (is_act(h2_col, h2_row)) ex_pix = exp_fb[(h2_row / 8) * 80 + h2_col / 8];
            check_val("rgb", rgb, ex_pix);
            check_val("hsync", o_HSync, raw_hs(h2_col));
            check_val("vsync", o_VSync, raw_vs(h2_row));
            check_val("fstart", o_Frame_Start, (h1_col == 0 && h1_row == 0));
            if (o_Frame_Start) fs_cnt++;
            check_val("ready", o_Wr_Ready, !is_slot(cur_col, cur_row));
            if (cur_row == 0 && o_Wr_Ready) rdy_row0++;
            check_val("scan_we", o_Mem_We, 0);
            if (is_slot(cur_col, cur_row))
                check_val("scan_addr", o_Mem_Addr, (cur_row / 8) * 80 + cur_col / 8);
            if (h2_row == 10 && h2_col == 12) check_val("cell81_px", rgb, 9'h1C0);
            if (h2_row == 10 && h2_col == 16) check_val("cell82_px", rgb, 9'h038);
            if (h2_row == 10 && h2_col == 7)  check_val("cell80_px", rgb, 9'h007);
            if (cur_row == 5 && cur_col == 657) check_val("hs_657", o_HSync, 1);
            if (cur_row == 5 && cur_col == 658) check_val("hs_658", o_HSync, 0);
            if (cur_row == 1) i_Wr_Valid = 1'b0;
            step();
        end
        check_val("scan_reach_row17", cur_row, 17);
        check_val("fstart_cnt", fs_cnt, 1);
        check_val("row0_ready_cnt", rdy_row0, 720);

        // Start pulse and host write together in a non-scan active cycle
        for (int k = 0; k < 8 && (cur_col % 8) != 3; k++) step();
        i_Wr_Valid    = 1'b1;
        i_Wr_Addr     = 13'd5;
        i_Wr_Data     = 9'h0F0;
        i_Clear_Start = 1'b1;
        i_Clear_Color = 9'h0C3;
        #1;
        check_val("both_ready", o_Wr_Ready, 1);
        check_val("both_we", o_Mem_We, 1);
        check_val("both_addr", o_Mem_Addr, 5);
        check_val("both_data", o_Mem_WData, 9'h0F0);
        step();
        i_Wr_Valid = 1'b0;
        i_Clear_Start = 1'b0;
        #1;
        check_val("both_busy", o_Busy, 1);
        check_val("both_ram", ram[5], 9'h0F0);

        // Abort the clear with reset once 2000 cells are written
        wr = 0; bad_seq = 0; bad_slot = 0;
        for (int cyc = 0; cyc < 4000 && wr < 2000; cyc++) begin
            if (o_Mem_We) begin
                if (o_Mem_Addr != 13'(wr) || o_Mem_WData != 9'h0C3) bad_seq++;
                if (is_slot(cur_col, cur_row)) bad_slot++;
                wr++;
            end
            step();
        end
        i_Reset = 1'b1;
        #1;
        check_val("rst_mid_we", o_Mem_We, 0);
        check_val("rst_mid_ready", o_Wr_Ready, 0);
        step();
        check_val("rst_mid_busy", o_Busy, 0);
        check_val("rst_mid_rgb", rgb, 0);
        check_val("rst_mid_hsync", o_HSync, 1);
        check_val("rst_mid_vsync", o_VSync, 1);
        i_Reset = 1'b0;
        step();
        step();
        check_val("abort_idle", o_Busy, 0);
        check_val("abort_writes", wr, 2000);
        check_val("abort_seq", bad_seq, 0);
        check_val("abort_slot", bad_slot, 0);
        check_val("abort_ram1999", ram[1999], 9'h0C3);
        check_val("abort_ram2000", ram[2000], 9'h007);

        // Fresh clear during active video restarts from address 0
        i_Clear_Start = 1'b1;
        i_Clear_Color = 9'h124;
        step();
        i_Clear_Start = 1'b0;
        #1;
        check_val("clr2_busy", o_Busy, 1);
        wr = 0; bad_seq = 0; bad_slot = 0; bad_rdy = 0; first_addr = -1;
        for (int cyc = 0; cyc < 7000 && o_Busy; cyc++) begin
            if (o_Wr_Ready) bad_rdy++;
            if (o_Mem_We) begin
                if (first_addr < 0) first_addr = int'(o_Mem_Addr);
                if (o_Mem_Addr != 13'(wr) || o_Mem_WData != 9'h124) bad_seq++;
                if (is_slot(cur_col, cur_row)) bad_slot++;
                wr++;
            end
            step();
        end
        check_val("clr2_done", o_Busy, 0);
        check_val("clr2_first", first_addr, 0);
        check_val("clr2_writes", wr, 4800);
        check_val("clr2_seq", bad_seq, 0);
        check_val("clr2_slot", bad_slot, 0);
        check_val("clr2_ready", bad_rdy, 0);
        bad = 0;
        for (int i = 0; i < 4800; i++) if (ram[i] != 9'h124) bad++;
        check_val("clr2_ram", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
